// File: rtl/time_set_controller.sv
// Time-set controller: the mode button walks RUN -> SET_HOUR -> SET_MIN -> COMMIT,
// up/down presses and held-button auto-repeat edit the selected field, and an
// idle edit times out back to RUN without loading the timekeeper.
module time_set_controller #(
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
  parameter int unsigned TIMEOUT       = 32'd3_000_000_000,
  parameter int unsigned BLINK_HALF    = 25_000_000,
  localparam int unsigned HOUR_W       = 5,
  localparam int unsigned MIN_W        = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              modePress,
  input  logic              upPress,
  input  logic              downPress,
  input  logic              upHeld,
  input  logic              downHeld,
  input  logic [HOUR_W-1:0] timeHours,
  input  logic [MIN_W-1:0]  timeMinutes,
  output logic              editing,
  output logic              editField,
  output logic              blinkPhase,
  output logic [HOUR_W-1:0] editHours,
  output logic [MIN_W-1:0]  editMinutes,
  output logic              loadEn,
  output logic [HOUR_W-1:0] loadHours,
  output logic [MIN_W-1:0]  loadMinutes
);

  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam int unsigned IDLE_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned BLINK_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [HOUR_W-1:0]  MAX_HOUR   = HOUR_W'(23);
  localparam logic [MIN_W-1:0]   MAX_MIN    = MIN_W'(59);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
  localparam logic [HOLD_W-1:0]  HOLD_FIRST = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0]  HOLD_NEXT  = HOLD_W'(REPEAT_PERIOD);

  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, COMMIT} stateT;

  stateT               state, stateNext;
  logic [HOLD_W-1:0]   holdCnt, holdCntNext, holdInc;
  logic                repeating, repeatingNext;
  logic [IDLE_W-1:0]   idleCnt, idleCntNext;
  logic [BLINK_W-1:0]  blinkCnt, blinkCntNext;
  logic                blinkNext;
  logic [HOUR_W-1:0]   editHoursNext, loadHoursNext;
  logic [MIN_W-1:0]    editMinutesNext, loadMinutesNext;
  logic                oneHeld, anyInput, autoStep, stepUp, stepDown;

  // Input qualifiers shared by the auto-repeat and timeout logic
  assign oneHeld  = upHeld ^ downHeld;
  assign anyInput = modePress | upPress | downPress | upHeld | downHeld;
  assign holdInc  = holdCnt + HOLD_W'(1);

  // Next-state, edit arithmetic, auto-repeat, timeout and blink decisions
  always_comb begin
    stateNext       = state;
    editHoursNext   = editHours;
    editMinutesNext = editMinutes;
    loadHoursNext   = loadHours;
    loadMinutesNext = loadMinutes;
    holdCntNext     = '0;
    repeatingNext   = 1'b0;
    idleCntNext     = '0;
    blinkCntNext    = '0;
    blinkNext       = 1'b1;
    autoStep        = 1'b0;
    stepUp          = 1'b0;
    stepDown        = 1'b0;

    case (state)
      RUN: begin
        if (modePress) begin
          stateNext       = SET_HOUR;
          editHoursNext   = timeHours;
          editMinutesNext = timeMinutes;
        end
      end

      SET_HOUR, SET_MIN: begin
        // First repeat after REPEAT_DELAY held cycles, then every REPEAT_PERIOD
        if (oneHeld) begin
          repeatingNext = repeating;
          holdCntNext   = holdInc;
          if (holdInc == (repeating ? HOLD_NEXT : HOLD_FIRST)) begin
            autoStep      = 1'b1;
            holdCntNext   = '0;
            repeatingNext = 1'b1;
          end
        end

        // Mode wins over any step; opposing presses cancel each other
        if (!modePress && !(upPress && downPress)) begin
          if (upPress) begin
            stepUp = 1'b1;
          end else if (downPress) begin
            stepDown = 1'b1;
          end else if (autoStep) begin
            stepUp   = upHeld;
            stepDown = downHeld;
          end
        end

        if (state == SET_HOUR) begin
          if (stepUp) begin
            editHoursNext = (editHours == MAX_HOUR) ? HOUR_W'(0) : editHours + HOUR_W'(1);
          end else if (stepDown) begin
            editHoursNext = (editHours == HOUR_W'(0)) ? MAX_HOUR : editHours - HOUR_W'(1);
          end
        end else begin
          if (stepUp) begin
            editMinutesNext = (editMinutes == MAX_MIN) ? MIN_W'(0) : editMinutes + MIN_W'(1);
          end else if (stepDown) begin
            editMinutesNext = (editMinutes == MIN_W'(0)) ? MAX_MIN : editMinutes - MIN_W'(1);
          end
        end

        if (anyInput) begin
          idleCntNext = '0;
        end else if (idleCnt == IDLE_LAST) begin
          stateNext = RUN;
        end else begin
          idleCntNext = idleCnt + IDLE_W'(1);
        end

        if (modePress) begin
          stateNext = (state == SET_HOUR) ? SET_MIN : COMMIT;
        end

        if (blinkCnt == BLINK_LAST) begin
          blinkCntNext = '0;
          blinkNext    = ~blinkPhase;
        end else begin
          blinkCntNext = blinkCnt + BLINK_W'(1);
          blinkNext    = blinkPhase;
        end
      end

      COMMIT: begin
        stateNext = RUN;
      end

      default: begin
        stateNext = RUN;
      end
    endcase

    // Every state change restarts the counters and the blink phase
    if (stateNext != state) begin
      holdCntNext   = '0;
      repeatingNext = 1'b0;
      idleCntNext   = '0;
      blinkCntNext  = '0;
      blinkNext     = 1'b1;
    end

    if (stateNext == COMMIT) begin
      loadHoursNext   = editHoursNext;
      loadMinutesNext = editMinutesNext;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      holdCnt     <= '0;
      repeating   <= 1'b0;
      idleCnt     <= '0;
      blinkCnt    <= '0;
      editing     <= 1'b0;
      editField   <= 1'b0;
      blinkPhase  <= 1'b1;
      editHours   <= '0;
      editMinutes <= '0;
      loadEn      <= 1'b0;
      loadHours   <= '0;
      loadMinutes <= '0;
    end else begin
      state       <= stateNext;
      holdCnt     <= holdCntNext;
      repeating   <= repeatingNext;
      idleCnt     <= idleCntNext;
      blinkCnt    <= blinkCntNext;
      editing     <= (stateNext == SET_HOUR) || (stateNext == SET_MIN);
      editField   <= (stateNext == SET_MIN);
      blinkPhase  <= blinkNext;
      editHours   <= editHoursNext;
      editMinutes <= editMinutesNext;
      loadEn      <= (stateNext == COMMIT);
      loadHours   <= loadHoursNext;
      loadMinutes <= loadMinutesNext;
    end
  end

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the edit rules.
module tb_time_set_controller;

  localparam int RD = 8;
  localparam int RP = 4;
  localparam int TO = 100;
  localparam int BH = 5;

  // Button vector {modePress, upPress, downPress, upHeld, downHeld}
  localparam logic [4:0] IDLE  = 5'b00000;
  localparam logic [4:0] MODE  = 5'b10000;
  localparam logic [4:0] UP    = 5'b01000;
  localparam logic [4:0] DOWN  = 5'b00100;
  localparam logic [4:0] UHELD = 5'b00010;
  localparam logic [4:0] DHELD = 5'b00001;

  logic       clk = 1'b0;
  logic       reset, modePress, upPress, downPress, upHeld, downHeld;
  logic [4:0] timeHours;
  logic [5:0] timeMinutes;
  logic       editing, editField, blinkPhase, loadEn;
  logic [4:0] editHours, loadHours;
  logic [5:0] editMinutes, loadMinutes;

  int nChecks = 0;
  int nFails  = 0;

  // Model: mState 0=run 1=hours 2=minutes 3=commit
  int mState = 0;
  int mEditH = 0, mEditM = 0, mLoadH = 0, mLoadM = 0;
  bit mLoadEn = 1'b0;
  int mHoldK = 0, mIdleRun = 0, mBlinkCyc = 0;

  time_set_controller #(
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .TIMEOUT      (TO),
    .BLINK_HALF   (BH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .modePress  (modePress),
    .upPress    (upPress),
    .downPress  (downPress),
    .upHeld     (upHeld),
    .downHeld   (downHeld),
    .timeHours  (timeHours),
    .timeMinutes(timeMinutes),
    .editing    (editing),
    .editField  (editField),
    .blinkPhase (blinkPhase),
    .editHours  (editHours),
    .editMinutes(editMinutes),
    .loadEn     (loadEn),
    .loadHours  (loadHours),
    .loadMinutes(loadMinutes)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", nFails);
    $fatal(1);
  end

  // Advance the model by one clock with the inputs currently applied
  task automatic modelEdge();
    int  nextState;
    int  dir;
    bit  held1, autoFire, act;
    nextState = mState;
    dir       = 0;
    mLoadEn   = 1'b0;
    if (reset) begin
      mState = 0; mEditH = 0; mEditM = 0; mLoadH = 0; mLoadM = 0;
      mHoldK = 0; mIdleRun = 0; mBlinkCyc = 0;
      return;
    end
    case (mState)
      0: if (modePress) begin
        nextState = 1;
        mEditH    = int'(timeHours);
        mEditM    = int'(timeMinutes);
      end
      1, 2: begin
        held1    = upHeld ^ downHeld;
        mHoldK   = held1 ? mHoldK + 1 : 0;
        autoFire = held1 && (mHoldK == RD || (mHoldK > RD && (mHoldK - RD) % RP == 0));
        if (!modePress && !(upPress && downPress)) begin
          if (upPress) dir = 1;
          else if (downPress) dir = -1;
          else if (autoFire) dir = upHeld ? 1 : -1;
        end
        if (mState == 1) mEditH = (mEditH + dir + 24) % 24;
        else             mEditM = (mEditM + dir + 60) % 60;
        act      = modePress | upPress | downPress | upHeld | downHeld;
        mIdleRun = act ? 0 : mIdleRun + 1;
        if (modePress) nextState = (mState == 1) ? 2 : 3;
        else if (mIdleRun == TO) nextState = 0;
        mBlinkCyc++;
      end
      default: nextState = 0;
    endcase
    if (nextState != mState) begin
      mHoldK = 0; mIdleRun = 0; mBlinkCyc = 0;
    end
    if (nextState == 3) begin
      mLoadEn = 1'b1;
      mLoadH  = mEditH;
      mLoadM  = mEditM;
    end
    mState = nextState;
  endtask

  // Apply inputs for one cycle, update the model, sample after the edge
  task automatic cycle(input logic r, input logic [4:0] btn);
    @(negedge clk);
    reset = r;
    {modePress, upPress, downPress, upHeld, downHeld} = btn;
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, IDLE);
    cycle(1'b1, MODE);
    nChecks++;
    if ({editing, editField, blinkPhase, loadEn} !== 4'b0010) begin
      nFails++;
      $display("FAIL reset_flags: got %b expected 0010", {editing, editField, blinkPhase, loadEn});
    end
    nChecks++;
    if ({editHours, editMinutes, loadHours, loadMinutes} !== 22'd0) begin
      nFails++;
      $display("FAIL reset_values: got %h expected 0", {editHours, editMinutes, loadHours, loadMinutes});
    end
    cycle(1'b0, UP | UHELD);
    nChecks++;
    if ({editing, blinkPhase, loadEn, editHours} !== {3'b010, 5'd0}) begin
      nFails++;
      $display("FAIL run_ignores_up: got %b expected 010_00000", {editing, blinkPhase, loadEn, editHours});
    end
  endtask

  task automatic test_commit_wrap();
    timeHours = 5'd23; timeMinutes = 6'd59;
    cycle(1'b0, MODE);
    nChecks++;
    if ({editing, editField, blinkPhase, loadEn, editHours, editMinutes} !== {4'b1010, 5'd23, 6'd59}) begin
      nFails++;
      $display("FAIL enter_set_hour: got %h expected %h",
               {editing, editField, blinkPhase, loadEn, editHours, editMinutes}, {4'b1010, 5'd23, 6'd59});
    end
    cycle(1'b0, UP);
    nChecks++;
    if (editHours !== 5'd0) begin
      nFails++; $display("FAIL hour_wrap_up: got %0d expected 0", editHours);
    end
    cycle(1'b0, MODE);
    nChecks++;
    if ({editing, editField} !== 2'b11) begin
      nFails++; $display("FAIL enter_set_min: got %b expected 11", {editing, editField});
    end
    cycle(1'b0, UP);
    nChecks++;
    if ({editHours, editMinutes} !== {5'd0, 6'd0}) begin
      nFails++; $display("FAIL min_wrap_up: got %0d:%0d expected 0:0", editHours, editMinutes);
    end
    cycle(1'b0, MODE);
    nChecks++;
    if ({loadEn, editing, loadHours, loadMinutes} !== {2'b10, 5'd0, 6'd0}) begin
      nFails++;
      $display("FAIL commit_load: got en=%b ed=%b %0d:%0d expected en=1 ed=0 0:0",
               loadEn, editing, loadHours, loadMinutes);
    end
    cycle(1'b0, IDLE);
    nChecks++;
    if ({loadEn, editing, blinkPhase} !== 3'b001) begin
      nFails++; $display("FAIL load_single_pulse: got %b expected 001", {loadEn, editing, blinkPhase});
    end
  endtask

  task automatic test_minute_down();
    timeHours = 5'd10; timeMinutes = 6'd0;
    cycle(1'b0, MODE);
    cycle(1'b0, MODE);
    cycle(1'b0, DOWN);
    nChecks++;
    if ({editHours, editMinutes} !== {5'd10, 6'd59}) begin
      nFails++; $display("FAIL min_wrap_down: got %0d:%0d expected 10:59", editHours, editMinutes);
    end
    cycle(1'b0, MODE);
    nChecks++;
    if ({loadEn, loadHours, loadMinutes} !== {1'b1, 5'd10, 6'd59}) begin
      nFails++; $display("FAIL commit_values: got en=%b %0d:%0d expected en=1 10:59", loadEn, loadHours, loadMinutes);
    end
    cycle(1'b0, IDLE);
  endtask

  task automatic test_auto_repeat();
    int expH;
    timeHours = 5'd5; timeMinutes = 6'd30;
    cycle(1'b0, MODE);
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b0, UHELD);
      expH = 5 + ((k < RD) ? 0 : 1 + (k - RD) / RP);
      nChecks++;
      if (editHours !== 5'(expH)) begin
        nFails++; $display("FAIL auto_repeat_up k=%0d: got %0d expected %0d", k, editHours, expH);
      end
    end
    cycle(1'b0, IDLE);
    for (int k = 1; k <= RD; k++) cycle(1'b0, DHELD);
    nChecks++;
    if ({editHours, editMinutes} !== {5'd8, 6'd30}) begin
      nFails++; $display("FAIL auto_repeat_down: got %0d:%0d expected 8:30", editHours, editMinutes);
    end
    cycle(1'b0, MODE);
    cycle(1'b0, MODE);
    nChecks++;
    if ({loadEn, loadHours, loadMinutes} !== {1'b1, 5'd8, 6'd30}) begin
      nFails++; $display("FAIL repeat_commit: got en=%b %0d:%0d expected en=1 8:30", loadEn, loadHours, loadMinutes);
    end
    cycle(1'b0, IDLE);
  endtask

  task automatic test_timeout();
    bit sawLoad;
    sawLoad = 1'b0;
    timeHours = 5'd14; timeMinutes = 6'd45;
    cycle(1'b0, MODE);
    for (int k = 1; k < TO; k++) begin
      cycle(1'b0, IDLE);
      if (loadEn === 1'b1) sawLoad = 1'b1;
    end
    nChecks++;
    if (editing !== 1'b1) begin
      nFails++; $display("FAIL timeout_early: editing=%b after %0d idle cycles, expected 1", editing, TO - 1);
    end
    cycle(1'b0, IDLE);
    if (loadEn === 1'b1) sawLoad = 1'b1;
    nChecks++;
    if ({editing, loadEn, sawLoad, blinkPhase, editHours} !== {4'b0001, 5'd14}) begin
      nFails++;
      $display("FAIL timeout_abort: got ed=%b en=%b sawLoad=%b blink=%b h=%0d expected 0 0 0 1 14",
               editing, loadEn, sawLoad, blinkPhase, editHours);
    end
    cycle(1'b0, IDLE);
    nChecks++;
    if ({editing, loadEn} !== 2'b00) begin
      nFails++; $display("FAIL timeout_stays_run: got %b expected 00", {editing, loadEn});
    end
  endtask

  task automatic test_simultaneous();
    timeHours = 5'd7; timeMinutes = 6'd20;
    cycle(1'b0, MODE);
    cycle(1'b0, MODE | UP);
    nChecks++;
    if ({editing, editField, editHours, editMinutes} !== {2'b11, 5'd7, 6'd20}) begin
      nFails++;
      $display("FAIL mode_beats_up: got ed=%b f=%b %0d:%0d expected 1 1 7:20", editing, editField, editHours, editMinutes);
    end
    cycle(1'b0, UP | DOWN);
    nChecks++;
    if ({editHours, editMinutes} !== {5'd7, 6'd20}) begin
      nFails++; $display("FAIL up_down_cancel: got %0d:%0d expected 7:20", editHours, editMinutes);
    end
    for (int k = 0; k < 3 * RD; k++) cycle(1'b0, UHELD | DHELD);
    nChecks++;
    if ({editing, editMinutes} !== {1'b1, 6'd20}) begin
      nFails++; $display("FAIL both_held_no_repeat: got ed=%b m=%0d expected 1 20", editing, editMinutes);
    end
    cycle(1'b0, MODE);
    cycle(1'b0, IDLE);
  endtask

  task automatic test_blink();
    bit expB;
    cycle(1'b0, MODE);
    for (int k = 0; k < 3 * BH; k++) begin
      if (k > 0) cycle(1'b0, IDLE);
      expB = ((k / BH) % 2 == 0);
      nChecks++;
      if (blinkPhase !== expB) begin
        nFails++; $display("FAIL blink_hour k=%0d: got %b expected %b", k, blinkPhase, expB);
      end
    end
    cycle(1'b0, MODE);
    nChecks++;
    if (blinkPhase !== 1'b1) begin
      nFails++; $display("FAIL blink_reentry: got %b expected 1", blinkPhase);
    end
    for (int k = 0; k < BH; k++) cycle(1'b0, IDLE);
    nChecks++;
    if (blinkPhase !== 1'b0) begin
      nFails++; $display("FAIL blink_min_toggle: got %b expected 0", blinkPhase);
    end
    cycle(1'b0, MODE);
    cycle(1'b0, IDLE);
    nChecks++;
    if ({editing, blinkPhase} !== 2'b01) begin
      nFails++; $display("FAIL blink_run: got %b expected 01", {editing, blinkPhase});
    end
  endtask

  task automatic test_reset_mid_edit();
    timeHours = 5'd3; timeMinutes = 6'd17;
    cycle(1'b0, MODE);
    cycle(1'b0, MODE);
    cycle(1'b1, IDLE);
    nChecks++;
    if ({editing, editField, blinkPhase, loadEn, editHours, editMinutes, loadHours, loadMinutes} !== {4'b0010, 22'd0}) begin
      nFails++;
      $display("FAIL reset_in_set_min: got %h expected %h",
               {editing, editField, blinkPhase, loadEn, editHours, editMinutes, loadHours, loadMinutes}, {4'b0010, 22'd0});
    end
    cycle(1'b0, IDLE);
    nChecks++;
    if ({editing, loadEn} !== 2'b00) begin
      nFails++; $display("FAIL after_reset_edit: got %b expected 00", {editing, loadEn});
    end
    cycle(1'b0, MODE);
    cycle(1'b0, MODE);
    cycle(1'b0, MODE);
    nChecks++;
    if ({loadEn, loadHours, loadMinutes} !== {1'b1, 5'd3, 6'd17}) begin
      nFails++; $display("FAIL commit_before_reset: got en=%b %0d:%0d expected en=1 3:17", loadEn, loadHours, loadMinutes);
    end
    cycle(1'b1, IDLE);
    cycle(1'b0, IDLE);
    nChecks++;
    if ({editing, loadEn, loadHours} !== {2'b00, 5'd0}) begin
      nFails++; $display("FAIL reset_in_commit: got %b expected 00_00000", {editing, loadEn, loadHours});
    end
  endtask

  task automatic test_random();
    logic        uhLvl, dhLvl, m, u, d, r;
    logic [25:0] actV, expV;
    bit          expB;
    uhLvl = 1'b0; dhLvl = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) uhLvl = ~uhLvl;
      if ($urandom_range(0, 29) == 0) dhLvl = ~dhLvl;
      m = ($urandom_range(0, 15) == 0);
      u = ($urandom_range(0, 9) == 0);
      d = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) begin
        timeHours   = 5'($urandom_range(0, 23));
        timeMinutes = 6'($urandom_range(0, 59));
      end
      cycle(r, {m, u, d, uhLvl, dhLvl});
      expB = (mState == 1 || mState == 2) ? ((mBlinkCyc / BH) % 2 == 0) : 1'b1;
      expV = {(mState == 1 || mState == 2), (mState == 2), expB, 5'(mEditH), 6'(mEditM),
              mLoadEn, 5'(mLoadH), 6'(mLoadM)};
      actV = {editing, editField, blinkPhase, editHours, editMinutes, loadEn, loadHours, loadMinutes};
      nChecks++;
      if (actV !== expV) begin
        nFails++; $display("FAIL random cycle %0d: got %h expected %h", i, actV, expV);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    {modePress, upPress, downPress, upHeld, downHeld} = IDLE;
    timeHours = 5'd0; timeMinutes = 6'd0;
    test_reset();
    test_commit_wrap();
    test_minute_down();
    test_auto_repeat();
    test_timeout();
    test_simultaneous();
    test_blink();
    test_reset_mid_edit();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/time_set_controller.md
TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

Interface
REQ-001 Parameter REPEAT_DELAY, default 50_000_000, is the hold duration in clk cycles before the first auto-repeat step.
REQ-002 Parameter REPEAT_PERIOD, default 10_000_000, is the clk cycles between subsequent auto-repeat steps.
REQ-003 Parameter TIMEOUT, default 3_000_000_000, is the idle clk cycles in an edit state before abandoning the edit.
REQ-004 Parameter BLINK_HALF, default 25_000_000, is the clk cycles per blinkPhase half-period.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 modePress, upPress, downPress  in  1 each  one-cycle debounced press pulses.
REQ-008 upHeld, downHeld  in  1 each  debounced level, 1 while the button is held.
REQ-009 timeHours  in  5  current running hours, 0-23.
REQ-010 timeMinutes  in  6  current running minutes, 0-59.
REQ-011 editing  out  1  1 in SET_HOUR or SET_MIN.
REQ-012 editField  out  1  0 = hours being edited, 1 = minutes.
REQ-013 blinkPhase  out  1  display blink phase for the edited field.
REQ-014 editHours  out  5  / editMinutes  out  6  working values shown while editing.
REQ-015 loadEn  out  1  one-cycle pulse commanding the timekeeper to load loadHours/loadMinutes and zero seconds.
REQ-016 loadHours  out  5  / loadMinutes  out  6  values to load, valid when loadEn = 1.

Function
REQ-017 All outputs SHALL be registered; the FSM SHALL have states RUN, SET_HOUR, SET_MIN, COMMIT.
REQ-018 RUN + modePress at cycle n -> SET_HOUR at n+1, with editHours/editMinutes captured from timeHours/timeMinutes at cycle n.
REQ-019 SET_HOUR + modePress -> SET_MIN; SET_MIN + modePress -> COMMIT; COMMIT -> RUN unconditionally after one cycle.
REQ-020 In COMMIT, loadEn SHALL be 1 for exactly that cycle, with loadHours/loadMinutes equal to editHours/editMinutes; loadEn SHALL be 0 otherwise.
REQ-021 A step up or down SHALL modify only the field selected by editField: hours wrap 23->0 up and 0->23 down; minutes wrap 59->0 up and 0->59 down.
REQ-022 A step SHALL occur on upPress/downPress, and on auto-repeat.
REQ-023 Auto-repeat: holdCnt counts cycles while exactly one of upHeld/downHeld is 1 in an edit state.
REQ-024 On the first press, a step SHALL occur when holdCnt reaches REPEAT_DELAY, then again every REPEAT_PERIOD cycles thereafter.
REQ-025 holdCnt SHALL clear when both held inputs are 0, both are 1, or on any state change.
REQ-026 Simultaneous events: modePress SHALL take priority and suppress any step in the same cycle.
REQ-027 Simultaneous events: upPress and downPress in the same cycle SHALL produce no step.
REQ-028 Timeout: idleCnt clears on any press pulse or held input, and increments otherwise in edit states.
REQ-029 When idleCnt reaches TIMEOUT-1, the FSM SHALL go to RUN without loadEn.
REQ-030 blinkPhase SHALL reset to 1 on entry to each edit state, toggle every BLINK_HALF cycles while editing, and be 1 in RUN.
REQ-031 In RUN and COMMIT, up/down inputs SHALL be ignored and counters held at 0.
REQ-032 editHours/editMinutes SHALL retain their last values in RUN.

Reset
REQ-033 While reset = 1: state = RUN, editing = 0, editField = 0, blinkPhase = 1, loadEn = 0, edit/load values = 0, all counters = 0.
REQ-034 Reset asserted mid-edit or in COMMIT SHALL abort without a loadEn pulse on the following cycle.

Verification
Bench parameters: REPEAT_DELAY=8, REPEAT_PERIOD=4, TIMEOUT=100, BLINK_HALF=5.
REQ-035 timeHours=23, timeMinutes=59; sequence mode, up, mode, up, mode -> loadEn single pulse with loadHours=0, loadMinutes=0.
REQ-036 SET_MIN, editMinutes=0, downPress -> editMinutes=59 and editHours unchanged.
REQ-037 SET_HOUR, editHours=5, upHeld held 20 cycles (no upPress) -> steps at holdCnt 8, 12, 16, 20 -> editHours=9.
REQ-038 SET_HOUR, no input for 100 cycles -> RUN, editing=0, loadEn never asserted.
REQ-039 modePress and upPress in the same cycle in SET_HOUR -> SET_MIN with editHours unchanged; upPress+downPress together -> no change.
REQ-040 reset pulsed in SET_MIN -> next cycle RUN, all outputs at reset values, loadEn=0.
